// File: rtl/stream_sink_checker.sv
// Stream sink endpoint: programmable backpressure on in_ready, incrementing-sequence
// checker on accepted beats, and an upstream valid/data stability monitor.
module stream_sink_checker #(
  parameter int         W    = 8,
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [1:0]   stall_mode,
  input  logic         clear,
  output logic [15:0]  beat_count,
  output logic [15:0]  err_count,
  output logic         seq_err,
  output logic         proto_err,
  output logic [W-1:0] last_data
);

  localparam logic [7:0]   LFSR_INIT = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [W-1:0] ONE       = {{(W-1){1'b0}}, 1'b1};
  localparam logic [15:0]  CNT_MAX   = 16'hFFFF;

  localparam logic [1:0] MODE_ALWAYS = 2'd0;
  localparam logic [1:0] MODE_NEVER  = 2'd1;
  localparam logic [1:0] MODE_LFSR   = 2'd2;
  localparam logic [1:0] MODE_TOGGLE = 2'd3;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    TRACK      = 1'b1
  } seq_state_t;

  seq_state_t   r_state;
  logic [7:0]   r_lfsr;
  logic         r_ready;
  logic [W-1:0] r_expected;
  logic [15:0]  r_beat_count;
  logic [15:0]  r_err_count;
  logic         r_seq_err;
  logic [W-1:0] r_last_data;
  logic         r_proto_err;
  logic         r_stalled;
  logic [W-1:0] r_stall_data;

  logic [7:0]   w_lfsr_next;
  logic         w_ready_next;
  logic         w_handshake;
  logic         w_violation;

  // Taps for x^8+x^6+x^5+x^4+1 in a left-shifting register.
  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  always_comb begin
    w_ready_next = 1'b0;
    case (stall_mode)
      MODE_ALWAYS: w_ready_next = 1'b1;
      MODE_NEVER:  w_ready_next = 1'b0;
      MODE_LFSR:   w_ready_next = w_lfsr_next[0];
      MODE_TOGGLE: w_ready_next = ~r_ready;
      default:     w_ready_next = 1'b0;
    endcase
  end

  assign w_handshake = in_valid && r_ready;
  assign w_violation = r_stalled && (!in_valid || (in_data != r_stall_data));

  // Backpressure generator; the LFSR keeps running through clear and all modes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr  <= LFSR_INIT;
      r_ready <= 1'b0;
    end else begin
      r_lfsr  <= w_lfsr_next;
      r_ready <= w_ready_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stalled    <= 1'b0;
      r_stall_data <= '0;
      r_proto_err  <= 1'b0;
    end else if (clear) begin
      r_stalled    <= 1'b0;
      r_stall_data <= in_data;
      r_proto_err  <= 1'b0;
    end else begin
      r_stalled    <= in_valid && !r_ready;
      r_stall_data <= in_data;
      if (w_violation) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  // Sequence tracker; clear wins over a coincident handshake, which is then dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= WAIT_FIRST;
      r_expected   <= '0;
      r_beat_count <= '0;
      r_err_count  <= '0;
      r_seq_err    <= 1'b0;
      r_last_data  <= '0;
    end else if (clear) begin
      r_state      <= WAIT_FIRST;
      r_expected   <= '0;
      r_beat_count <= '0;
      r_err_count  <= '0;
      r_seq_err    <= 1'b0;
    end else begin
      r_seq_err <= 1'b0;
      if (w_handshake) begin
        r_last_data <= in_data;
        if (r_beat_count != CNT_MAX) begin
          r_beat_count <= r_beat_count + 16'd1;
        end
        case (r_state)
          WAIT_FIRST: begin
            r_expected <= in_data + ONE;
            r_state    <= TRACK;
          end
          TRACK: begin
            r_expected <= in_data + ONE;
            if (in_data != r_expected) begin
              r_seq_err <= 1'b1;
              if (r_err_count != CNT_MAX) begin
                r_err_count <= r_err_count + 16'd1;
              end
            end
          end
          default: r_state <= WAIT_FIRST;
        endcase
      end
    end
  end

  assign in_ready   = r_ready;
  assign beat_count = r_beat_count;
  assign err_count  = r_err_count;
  assign seq_err    = r_seq_err;
  assign proto_err  = r_proto_err;
  assign last_data  = r_last_data;

endmodule

// File: doc/stream_sink_checker.md
# stream_sink_checker

Consumer-side endpoint for the team's valid/ready streaming interface: it accepts beats from an upstream stage (e.g. a pipeline register slice), generates a programmable backpressure pattern on `in_ready`, checks that accepted data forms an incrementing sequence, and monitors the upstream side for handshake-rule violations. It sits at the tail of a streaming datapath in simulation benches and on-chip self-test paths, and exposes saturating beat and error counters for status readout.

## Interface
Parameters:
- `W`, 8: data width in bits (2..16).
- `SEED`, 8'hA5: initial LFSR value; a value of 0 is replaced by 8'h01.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  sink ready; driven directly from a flop.
- `in_data`  in  W  upstream beat data.
- `stall_mode`  in  2  backpressure mode: 0 = always ready, 1 = never ready, 2 = LFSR pseudo-random, 3 = alternate 1/0.
- `clear`  in  1  synchronous clear of counters, flags and sequence state; does not affect the LFSR.
- `beat_count`  out  16  accepted beats, saturating at 16'hFFFF.
- `err_count`  out  16  sequence mismatches, saturating at 16'hFFFF.
- `seq_err`  out  1  one-cycle pulse on each sequence mismatch.
- `proto_err`  out  1  sticky upstream protocol-violation flag.
- `last_data`  out  W  data of the most recent accepted beat.

## Operation
- A handshake occurs at a rising edge where `in_valid && in_ready`.
- Sequence FSM:
  - Two states, WAIT_FIRST and TRACK.
  - WAIT_FIRST: the first handshake loads `expected = in_data + 1` (mod 2^W), performs no check, and moves to TRACK.
  - TRACK: each handshake compares `in_data` with `expected`.
    - On a match, `expected` increments (mod 2^W).
    - On a mismatch, `err_count` increments, `seq_err` pulses, and the sequence resyncs with `expected = in_data + 1`.
  - `clear` returns the FSM to WAIT_FIRST.
- Every handshake increments `beat_count` and loads `last_data`.
- Protocol monitor:
  - Registers `stalled = in_valid && !in_ready` each cycle, together with the `in_data` value seen in that cycle.
  - If `stalled` was set in the previous cycle and now either `in_valid` is 0 or `in_data` differs from the registered value, `proto_err` sets.
  - `proto_err` is cleared only by `rst` or `clear`.
- Backpressure generator:
  - LFSR is 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifting every cycle regardless of mode.
  - Next `in_ready` value by mode:
    - Mode 0: 1.
    - Mode 1: 0.
    - Mode 2: the LFSR bit 0 value after this cycle's shift.
    - Mode 3: the inverse of the current `in_ready`.
- Counters saturate: at 16'hFFFF they hold, and no wrap to 0 occurs.

## Timing
- Reset values:
  - `in_ready` = 0, `beat_count` = 0, `err_count` = 0, `seq_err` = 0, `proto_err` = 0, `last_data` = 0.
  - FSM = WAIT_FIRST, LFSR = SEED (or 8'h01 if SEED = 0), stall tracker cleared.
- First rising edge after `rst` deasserts: `in_ready` takes its mode-determined value.
- A `stall_mode` change affects `in_ready` starting at the next edge (one cycle latency).
- For a handshake at edge N, `beat_count`, `last_data`, `err_count` and `seq_err` reflect it after edge N. `seq_err` is high for exactly the cycle following edge N.
- A protocol violation detected at edge N sets `proto_err` after edge N.
- `clear` coincident with a handshake:
  - `clear` wins: counters become 0, FSM goes to WAIT_FIRST, and the beat is accepted upstream but not counted.
- Mode 3 while in WAIT_FIRST or TRACK is independent of `in_valid`; `in_ready` toggles every cycle.
- `rst` asserted mid-stream forces every output to its reset value immediately, without waiting for a clock. Any beat presented in that cycle is not accepted.
- `in_ready` never depends combinationally on `in_valid`.
- Back-to-back handshakes every cycle are supported in mode 0 (throughput 1 beat/cycle).

## Test plan
- Reset, then mode 0 with data 8'h01..8'h0A on consecutive cycles -> `beat_count` = 10, `err_count` = 0, `last_data` = 8'h0A, `proto_err` = 0.
- Mode 0 with sequence 8'h03, 8'h04, 8'h07, 8'h08 -> a single `seq_err` pulse, the cycle after 8'h07 is accepted; `err_count` = 1, `beat_count` = 4.
- Mode 1 for 3 cycles with `in_valid` = 1, `in_data` = 8'h05 held, then mode 0 -> no handshake during the stall, exactly one accept of 8'h05, `proto_err` = 0.
- Mode 1 with 8'h08 held one cycle, then `in_valid` dropped (or data changed to 8'h09) -> `proto_err` = 1 and stays 1 until `clear`.
- Mode 2 with SEED = 8'hA5 and a continuous incrementing source starting at 8'hFE -> `in_ready` matches the LFSR model every cycle; the wrap 8'hFF -> 8'h00 produces no error.
- `clear` asserted in the same cycle as a handshake, after 5 beats -> counters = 0, next beat re-enters WAIT_FIRST with no error. Async `rst` mid-stream -> all outputs are at reset values before the next edge.
